// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Fetch entries, FSM states and instruction size.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_TRAP
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-2 FIFO of fetch entries.
// Flush has priority; simultaneous push and pop keep the count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;

  assign do_pop = pop & (count != '0);
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// PC sequencing, 1-cycle memory fetch and decode handoff.
// FETCH_MISALIGN_TRAP_EN enables the misaligned-PC trap state.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

  fetch_state_t  state;
  fetch_state_t  state_nx;
  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          kill;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          push;
  logic          pop;
  logic          credit_ok;
  logic          try_issue;
  logic          issue;
  logic          trap_go;

  assign mem_addr   = pc;
  assign out_valid  = (count != '0);
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;
  assign push_entry = '{pc: inflight_pc, instr: mem_rdata};

  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = inflight & ~kill & ~redirect_valid;

  // A same-cycle pop frees a slot before the next return lands
  assign credit_ok = (count + CW'(inflight))
                   < (CW'(FIFO_DEPTH) + CW'(pop));

  assign try_issue = fetch_en & (state != FS_TRAP)
                   & ~redirect_valid & credit_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned  = (pc[1:0] != 2'b00);
  assign issue       = try_issue & ~misaligned;
  assign trap_go     = try_issue & misaligned;
  assign fetch_fault = (state == FS_TRAP);
`else
  assign issue       = try_issue;
  assign trap_go     = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      FS_IDLE: if (fetch_en)  state_nx = FS_RUN;
      FS_RUN:  if (!fetch_en) state_nx = FS_IDLE;
      FS_TRAP: state_nx = FS_TRAP;
      default: state_nx = FS_IDLE;
    endcase
    if (trap_go) state_nx = FS_TRAP;
    if (redirect_valid) begin
      state_nx = fetch_en ? FS_RUN : FS_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FS_IDLE;
      pc          <= RESET_PC & PC_MASK;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      state <= state_nx;
      kill  <= redirect_valid;
      if (redirect_valid) begin
        pc       <= redirect_pc & PC_MASK;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= pc;
          pc          <= pc + 32'(INSTR_BYTES);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .flush   (redirect_valid),
    .head    (head),
    .count   (count)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl.
// Memory model returns word(addr) = addr >> 2.
module tb_instr_fetch_ctrl;

  logic        clock;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int n_chk;
  int n_fail;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
  } vec_t;

  vec_t tbl[$];

  instr_fetch_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) mem_rdata <= mem_addr >> 2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic fe, input logic rdy,
                     input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc,
                     input logic [31:0] ein);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ein = ein;
    tbl.push_back(v);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // idle, then stream from reset
    add(0, 1, 0, 0, 0, 32'h0, 32'h0);
    add(1, 1, 0, 0, 0, 32'h0, 32'h0);
    add(1, 1, 0, 0, 1, 32'h0, 32'h0);
    add(1, 1, 0, 0, 1, 32'h4, 32'h1);
    add(1, 1, 0, 0, 1, 32'h8, 32'h2);
    add(1, 1, 0, 0, 1, 32'hC, 32'h3);
    // back-pressure: head holds, fifo fills to 2
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 1, 32'hC, 32'h3);
    add(1, 1, 0, 0, 1, 32'h10, 32'h4);
    add(1, 1, 0, 0, 1, 32'h14, 32'h5);
    add(1, 1, 0, 0, 1, 32'h18, 32'h6);
    // redirect with entry queued and a read in flight
    add(1, 0, 1, 32'h100, 0, 32'h0, 32'h0);
    add(1, 1, 0, 0, 0, 32'h0, 32'h0);
    add(1, 1, 0, 0, 1, 32'h100, 32'h40);
    add(1, 1, 0, 0, 1, 32'h104, 32'h41);
    // wrap at top of address space
    add(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
    add(1, 1, 0, 0, 0, 32'h0, 32'h0);
    add(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    add(1, 1, 0, 0, 1, 32'h0, 32'h0);
    add(1, 1, 0, 0, 1, 32'h4, 32'h1);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      fetch_en = tbl[i].fe;
      out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid),
          32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("v%0d_instr", i), out_instr, tbl[i].ein);
      end
    end

    // asynchronous reset with one entry queued
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_addr", mem_addr, 32'h0);
    chk("async_fault", 32'(fetch_fault), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("rs_valid0", 32'(out_valid), 32'h0);
    step();
    chk("rs_valid1", 32'(out_valid), 32'h1);
    chk("rs_pc1", out_pc, 32'h0);
    chk("rs_instr1", out_instr, 32'h0);
    step();
    chk("rs_pc2", out_pc, 32'h4);
    chk("rs_instr2", out_instr, 32'h1);

    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("mis_valid0", 32'(out_valid), 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_addr", mem_addr, 32'h102);
    step();
    chk("trap_fault1", 32'(fetch_fault), 32'h1);
    chk("trap_valid1", 32'(out_valid), 32'h0);
    step();
    chk("trap_fault2", 32'(fetch_fault), 32'h1);
    chk("trap_valid2", 32'(out_valid), 32'h0);
    chk("trap_addr", mem_addr, 32'h102);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("trap_clr", 32'(fetch_fault), 32'h0);
    step();
    chk("trap_valid3", 32'(out_valid), 32'h0);
    step();
    chk("trap_valid4", 32'(out_valid), 32'h1);
    chk("trap_pc", out_pc, 32'h200);
    chk("trap_instr", out_instr, 32'h80);
`else
    chk("mis_addr", mem_addr, 32'h100);
    step();
    chk("mis_valid1", 32'(out_valid), 32'h0);
    step();
    chk("mis_valid2", 32'(out_valid), 32'h1);
    chk("mis_pc", out_pc, 32'h100);
    chk("mis_instr", out_instr, 32'h40);
    chk("mis_fault", 32'(fetch_fault), 32'h0);
    step();
    chk("mis_pc2", out_pc, 32'h104);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
